// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store bus controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Size 11 is never legal; halves need an even address, words a word address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Word-aligned memory bus between the LSU controller (master) and memory (slave).
interface lsu_bus_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: enables and replicated store data for the request,
// and the load word shifted so the addressed byte lands at bit 0.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_shift
);

    assign be = be_for(size, off);

    // Replicate the right-aligned store data so every enabled lane sees it.
    always_comb begin
        case (size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    assign rdata_shift = rdata_in >> {rd_off, 3'b000};

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns one core request into one word-aligned
// bus transaction and stalls the core until the response (or timeout).
//
// state | meaning
// IDLE  | no access outstanding; misaligned requests are answered here
// REQ   | bus_req_o high, waiting for grant
// WAIT  | granted, waiting for bus_rvalid_i
// RESP  | done_o pulse, error flag presented, core released
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    lsu_bus_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             err_q;

    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shift;
    logic        illegal;
    logic        idle_req;
    logic        accept;
    logic        tmo;

    lsu_lane_align u_align (
        .size        (size_i),
        .off         (addr_i[1:0]),
        .wdata       (wdata_i),
        .rd_off      (addr_q[1:0]),
        .rdata_in    (bus.bus_rdata_i),
        .be          (be_new),
        .wdata_rep   (wdata_new),
        .rdata_shift (rdata_shift)
    );

    // Gating with rst_ni keeps the combinational outputs at 0 while reset is
    // held, even if the core keeps its request asserted.
    assign illegal  = is_misaligned(size_i, addr_i[1:0]);
    assign idle_req = rst_ni && (state == IDLE) && req_valid_i;
    assign accept   = idle_req && !illegal;
    assign tmo      = (cnt == CNT_LAST);

    assign stall_o      = accept || (state == REQ) || (state == WAIT);
    assign done_o       = (idle_req && illegal) || (state == RESP);
    assign misaligned_o = idle_req && illegal;
    assign bus_err_o    = (state == RESP) && err_q;

    assign bus.bus_req_o   = (state == REQ);
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus.bus_be_o    = be_q;
    assign bus.bus_wdata_o = wdata_q;

    // Sequencing FSM with timeout counter; the counter restarts on entry to
    // REQ and to WAIT so each phase gets the full timeout budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        be_q    <= be_new;
                        wdata_q <= wdata_new;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_gnt_i) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.bus_rvalid_i) begin
                        if (!we_q) begin
                            rdata_o <= rdata_shift;
                        end
                        err_q <= bus.bus_err_i;
                        state <= RESP;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
